// File: rtl/pampy_ctrl_pkg.sv
// Shared encodings for the pamPy control bus: FSM states, opcodes, mux/ULA selects.
// Imported by the control unit, the datapath blocks and the bench.
package pampy_ctrl_pkg;

    typedef enum logic [3:0] {
        StInit,
        StFetch,
        StDecode,
        StEx1,
        StEx2,
        StEx3,
        StPc1,
        StPc2,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        OpcNop,
        OpcLoadConst,
        OpcAdd,
        OpcSub,
        OpcCmp,
        OpcJump,
        OpcPopJump,
        OpcCall,
        OpcReturn,
        OpcUnknown
    } op_class_e;

    localparam logic [7:0] OpNop            = 8'h09;
    localparam logic [7:0] OpLoadConst      = 8'h64;
    localparam logic [7:0] OpBinaryAdd      = 8'h17;
    localparam logic [7:0] OpBinarySubtract = 8'h18;
    localparam logic [7:0] OpCompareOp      = 8'h6B;
    localparam logic [7:0] OpJumpAbsolute   = 8'h71;
    localparam logic [7:0] OpPopJumpIfFalse = 8'h72;
    localparam logic [7:0] OpCallFunction   = 8'h83;
    localparam logic [7:0] OpReturnValue    = 8'h53;

    localparam logic [3:0] UlaAdd     = 4'h0;
    localparam logic [3:0] UlaSub     = 4'h1;
    localparam logic [3:0] UlaCmp     = 4'h8;
    localparam logic [3:0] UlaPassOp1 = 4'hD;
    localparam logic [3:0] UlaZero    = 4'hE;
    localparam logic [3:0] UlaIncOp2  = 4'hF;

    localparam logic [1:0] OpndJumpArg = 2'd0;
    localparam logic [1:0] OpndStack   = 2'd1;
    localparam logic [1:0] OpndPc      = 2'd2;

    localparam logic PcFromUla  = 1'b0;
    localparam logic PcFromFunc = 1'b1;

    localparam logic [1:0] StkFromArg = 2'd0;
    localparam logic [1:0] StkFromRet = 2'd2;
    localparam logic [1:0] StkFromUla = 2'd3;

    localparam logic [1:0] StkHold = 2'b00;
    localparam logic [1:0] StkPush = 2'b01;
    localparam logic [1:0] StkPop  = 2'b10;

    localparam logic TosInc     = 1'b0;
    localparam logic TosDec     = 1'b1;
    localparam logic FuncTosInc = 1'b0;
    localparam logic FuncTosDec = 1'b1;

    // Number of execute states (EX1..EX3) each opcode class needs.
    function automatic logic [1:0] op_ex_len(op_class_e op);
        case (op)
            OpcLoadConst, OpcJump, OpcPopJump, OpcCall: return 2'd1;
            OpcAdd, OpcSub, OpcCmp, OpcReturn:          return 2'd3;
            default:                                    return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pampy_control_unit_if.sv
// Datapath control bus between the pamPy control unit (master) and blocks 1-4 (slave).
interface pampy_control_unit_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] REG_INSTR_IN;
    logic                  REG_COMP_IN;
    logic                  REG_OVERFLOW_IN;

    logic [1:0] SEL_MUX_OP1;
    logic [1:0] SEL_MUX_OP2;
    logic       CTRL_REG_OP1;
    logic       CTRL_REG_OP2;
    logic [3:0] SEL_ULA;
    logic       CTRL_REG_INSTR;
    logic       CTRL_REG_ARG;
    logic       CTRL_REG_JUMP;
    logic       CTRL_REG_PC;
    logic       SEL_MUX_PC;
    logic       CTRL_STACK_FUNCTION;
    logic       CTRL_REG_TOS_FUNCTION;
    logic       SEL_SOMADOR_SUBTRATOR;
    logic       CTRL_REG_DATA_RETURN;
    logic [1:0] SEL_MUX_STACK;
    logic [1:0] CTRL_REG_STACK;
    logic       CTRL_STACK;
    logic       CTRL_REG_TOS;
    logic       SEL_MUX_TOS;
    logic [1:0] CTRL_REG_MEM_EXT;
    logic       CTRL_MEM_EXT;
    logic       CTRL_REG_ADDR;
    logic       HALTED;

    modport master (
        input  REG_INSTR_IN, REG_COMP_IN, REG_OVERFLOW_IN,
        output SEL_MUX_OP1, SEL_MUX_OP2, CTRL_REG_OP1, CTRL_REG_OP2, SEL_ULA,
               CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_JUMP, CTRL_REG_PC, SEL_MUX_PC,
               CTRL_STACK_FUNCTION, CTRL_REG_TOS_FUNCTION, SEL_SOMADOR_SUBTRATOR,
               CTRL_REG_DATA_RETURN, SEL_MUX_STACK, CTRL_REG_STACK, CTRL_STACK,
               CTRL_REG_TOS, SEL_MUX_TOS, CTRL_REG_MEM_EXT, CTRL_MEM_EXT, CTRL_REG_ADDR,
               HALTED
    );

    modport slave (
        output REG_INSTR_IN, REG_COMP_IN, REG_OVERFLOW_IN,
        input  SEL_MUX_OP1, SEL_MUX_OP2, CTRL_REG_OP1, CTRL_REG_OP2, SEL_ULA,
               CTRL_REG_INSTR, CTRL_REG_ARG, CTRL_REG_JUMP, CTRL_REG_PC, SEL_MUX_PC,
               CTRL_STACK_FUNCTION, CTRL_REG_TOS_FUNCTION, SEL_SOMADOR_SUBTRATOR,
               CTRL_REG_DATA_RETURN, SEL_MUX_STACK, CTRL_REG_STACK, CTRL_STACK,
               CTRL_REG_TOS, SEL_MUX_TOS, CTRL_REG_MEM_EXT, CTRL_MEM_EXT, CTRL_REG_ADDR,
               HALTED
    );
endinterface

// File: rtl/pampy_opcode_decode.sv
// Opcode classifier: maps the raw bytecode to a class, execute length and jump flag.
module pampy_opcode_decode
    import pampy_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] opcode,
    output op_class_e             op_class,
    output logic                  known,
    output logic [1:0]            ex_len,
    output logic                  is_jump
);

    always_comb begin
        op_class = OpcUnknown;
        if      (opcode == DATA_WIDTH'(OpNop))            op_class = OpcNop;
        else if (opcode == DATA_WIDTH'(OpLoadConst))      op_class = OpcLoadConst;
        else if (opcode == DATA_WIDTH'(OpBinaryAdd))      op_class = OpcAdd;
        else if (opcode == DATA_WIDTH'(OpBinarySubtract)) op_class = OpcSub;
        else if (opcode == DATA_WIDTH'(OpCompareOp))      op_class = OpcCmp;
        else if (opcode == DATA_WIDTH'(OpJumpAbsolute))   op_class = OpcJump;
        else if (opcode == DATA_WIDTH'(OpPopJumpIfFalse)) op_class = OpcPopJump;
        else if (opcode == DATA_WIDTH'(OpCallFunction))   op_class = OpcCall;
        else if (opcode == DATA_WIDTH'(OpReturnValue))    op_class = OpcReturn;
    end

    assign known   = (op_class != OpcUnknown);
    assign ex_len  = op_ex_len(op_class);
    assign is_jump = (op_class == OpcJump) || (op_class == OpcPopJump) || (op_class == OpcCall);

endmodule

// File: rtl/pampy_control_unit.sv
// Multi-cycle control FSM for the pamPy bytecode datapath: fetch, decode, up to three
// execute steps, then a two-step PC update through the ULA.
module pampy_control_unit
    import pampy_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic                  clk,
    input logic                  reset,
    pampy_control_unit_if.master bus
);

    state_e    state_q, state_d;
    logic      taken_q, taken_d;
    op_class_e op_class;
    logic      known;
    logic [1:0] ex_len;
    logic      is_jump;

    logic       do_push;
    logic       do_pop;
    logic [1:0] push_src;

    pampy_opcode_decode #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_decode (
        .opcode   (bus.REG_INSTR_IN),
        .op_class (op_class),
        .known    (known),
        .ex_len   (ex_len),
        .is_jump  (is_jump)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        push_src = StkFromArg;

        bus.SEL_MUX_OP1           = 2'd0;
        bus.SEL_MUX_OP2           = 2'd0;
        bus.CTRL_REG_OP1          = 1'b0;
        bus.CTRL_REG_OP2          = 1'b0;
        bus.SEL_ULA               = 4'h0;
        bus.CTRL_REG_INSTR        = 1'b0;
        bus.CTRL_REG_ARG          = 1'b0;
        bus.CTRL_REG_JUMP         = 1'b0;
        bus.CTRL_REG_PC           = 1'b0;
        bus.SEL_MUX_PC            = 1'b0;
        bus.CTRL_STACK_FUNCTION   = 1'b0;
        bus.CTRL_REG_TOS_FUNCTION = 1'b0;
        bus.SEL_SOMADOR_SUBTRATOR = 1'b0;
        bus.CTRL_REG_DATA_RETURN  = 1'b0;
        bus.SEL_MUX_STACK         = 2'd0;
        bus.CTRL_REG_STACK        = StkHold;
        bus.CTRL_STACK            = 1'b0;
        bus.CTRL_REG_TOS          = 1'b0;
        bus.SEL_MUX_TOS           = 1'b0;
        bus.CTRL_REG_MEM_EXT      = 2'b00;
        bus.CTRL_MEM_EXT          = 1'b0;
        bus.CTRL_REG_ADDR         = 1'b0;
        bus.HALTED                = 1'b0;

        case (state_q)
            StInit: begin
                bus.SEL_ULA     = UlaZero;
                bus.CTRL_REG_PC = 1'b1;
                bus.SEL_MUX_PC  = PcFromUla;
                state_d         = StFetch;
            end
            StFetch: begin
                bus.CTRL_REG_INSTR = 1'b1;
                bus.CTRL_REG_ARG   = 1'b1;
                taken_d            = 1'b0;
                state_d            = StDecode;
            end
            StDecode: begin
                if (!known)             state_d = StHalt;
                else if (ex_len == 2'd0) state_d = StPc1;
                else                    state_d = StEx1;
            end
            StEx1: begin
                case (op_class)
                    OpcLoadConst: begin
                        do_push  = 1'b1;
                        push_src = StkFromArg;
                    end
                    OpcAdd, OpcSub, OpcCmp: begin
                        bus.SEL_MUX_OP2  = OpndStack;
                        bus.CTRL_REG_OP2 = 1'b1;
                        do_pop           = 1'b1;
                    end
                    OpcJump: bus.CTRL_REG_JUMP = 1'b1;
                    OpcPopJump: begin
                        bus.CTRL_REG_JUMP = 1'b1;
                        do_pop            = 1'b1;
                    end
                    OpcCall: begin
                        bus.CTRL_STACK_FUNCTION   = 1'b1;
                        bus.CTRL_REG_TOS_FUNCTION = 1'b1;
                        bus.SEL_SOMADOR_SUBTRATOR = FuncTosInc;
                        bus.CTRL_REG_JUMP         = 1'b1;
                    end
                    OpcReturn: begin
                        bus.CTRL_REG_DATA_RETURN = 1'b1;
                        do_pop                   = 1'b1;
                    end
                    default: ;
                endcase
                // The conditional jump is decided here, while the compare flag still
                // reflects the COMPARE_OP that preceded it.
                taken_d = is_jump && !((op_class == OpcPopJump) && bus.REG_COMP_IN);
                state_d = (ex_len == 2'd1) ? StPc1 : StEx2;
            end
            StEx2: begin
                case (op_class)
                    OpcAdd, OpcSub, OpcCmp: begin
                        bus.SEL_MUX_OP1  = OpndStack;
                        bus.CTRL_REG_OP1 = 1'b1;
                        do_pop           = 1'b1;
                    end
                    OpcReturn: begin
                        bus.CTRL_REG_TOS_FUNCTION = 1'b1;
                        bus.SEL_SOMADOR_SUBTRATOR = FuncTosDec;
                        bus.CTRL_REG_PC           = 1'b1;
                        bus.SEL_MUX_PC            = PcFromFunc;
                    end
                    default: ;
                endcase
                state_d = (ex_len == 2'd2) ? StPc1 : StEx3;
            end
            StEx3: begin
                state_d = StPc1;
                case (op_class)
                    OpcAdd, OpcSub, OpcCmp: begin
                        if (op_class == OpcAdd)      bus.SEL_ULA = UlaAdd;
                        else if (op_class == OpcSub) bus.SEL_ULA = UlaSub;
                        else                         bus.SEL_ULA = UlaCmp;
                        do_push  = 1'b1;
                        push_src = StkFromUla;
                        // Overflow still lets the result be written, then stops the machine.
                        if (op_class != OpcCmp && bus.REG_OVERFLOW_IN) state_d = StHalt;
                    end
                    OpcReturn: begin
                        do_push  = 1'b1;
                        push_src = StkFromRet;
                    end
                    default: ;
                endcase
            end
            StPc1: begin
                if (taken_q) begin
                    bus.SEL_MUX_OP1  = OpndJumpArg;
                    bus.CTRL_REG_OP1 = 1'b1;
                end else begin
                    bus.SEL_MUX_OP2  = OpndPc;
                    bus.CTRL_REG_OP2 = 1'b1;
                end
                state_d = StPc2;
            end
            StPc2: begin
                bus.SEL_ULA     = taken_q ? UlaPassOp1 : UlaIncOp2;
                bus.CTRL_REG_PC = 1'b1;
                bus.SEL_MUX_PC  = PcFromUla;
                state_d         = StFetch;
            end
            StHalt: begin
                bus.HALTED = 1'b1;
            end
            default: state_d = StInit;
        endcase

        if (do_push) begin
            bus.SEL_MUX_STACK  = push_src;
            bus.CTRL_REG_STACK = StkPush;
            bus.CTRL_STACK     = 1'b1;
            bus.CTRL_REG_TOS   = 1'b1;
            bus.SEL_MUX_TOS    = TosInc;
        end else if (do_pop) begin
            bus.CTRL_REG_STACK = StkPop;
            bus.CTRL_REG_TOS   = 1'b1;
            bus.SEL_MUX_TOS    = TosDec;
        end
    end

endmodule

// File: tb/tb_pampy_control_unit.sv
// Directed bench: a small behavioural datapath follows the control bus and executes
// short bytecode programs; PC, stack and control strobes are checked against hand values.
module tb_pampy_control_unit;
    import pampy_ctrl_pkg::*;

    logic clk;
    logic reset;
    logic comp_in;
    logic ovf_in;
    int   total;
    int   bad;

    pampy_control_unit_if #(.DATA_WIDTH(8)) bus ();

    pampy_control_unit #(
        .DATA_WIDTH (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath
    logic [7:0] prog_op  [256];
    logic [7:0] prog_arg [256];
    logic [7:0] m_pc, m_instr, m_arg, m_jump, m_op1, m_op2, m_ret;
    logic [7:0] ds [16];
    logic [3:0] sp;
    logic [7:0] fs [8];
    logic [2:0] fsp;
    logic [7:0] ula_out, ds_top, fs_top, push_val, op1_in, op2_in;
    logic [16:0] enables;

    assign bus.REG_INSTR_IN    = m_instr;
    assign bus.REG_COMP_IN     = comp_in;
    assign bus.REG_OVERFLOW_IN = ovf_in;

    assign ds_top = ds[sp - 4'd1];
    assign fs_top = fs[fsp - 3'd1];
    assign enables = {bus.CTRL_REG_OP1, bus.CTRL_REG_OP2, bus.CTRL_REG_INSTR, bus.CTRL_REG_ARG,
                      bus.CTRL_REG_JUMP, bus.CTRL_REG_PC, bus.CTRL_STACK_FUNCTION,
                      bus.CTRL_REG_TOS_FUNCTION, bus.CTRL_REG_DATA_RETURN, bus.CTRL_REG_STACK,
                      bus.CTRL_STACK, bus.CTRL_REG_TOS, bus.CTRL_REG_MEM_EXT, bus.CTRL_MEM_EXT,
                      bus.CTRL_REG_ADDR};

    always_comb begin
        ula_out = 8'h00;
        case (bus.SEL_ULA)
            4'h0: ula_out = m_op1 + m_op2;
            4'h1: ula_out = m_op1 - m_op2;
            4'h8: ula_out = {7'b0, m_op1 < m_op2};
            4'hD: ula_out = m_op1;
            4'hE: ula_out = 8'h00;
            4'hF: ula_out = m_op2 + 8'd1;
            default: ula_out = 8'h00;
        endcase
        push_val = 8'h00;
        case (bus.SEL_MUX_STACK)
            2'd0: push_val = m_arg;
            2'd2: push_val = m_ret;
            2'd3: push_val = ula_out;
            default: push_val = 8'h00;
        endcase
        op1_in = 8'h00;
        case (bus.SEL_MUX_OP1)
            2'd0: op1_in = m_jump;
            2'd1: op1_in = ds_top;
            2'd2: op1_in = m_pc;
            default: op1_in = 8'h00;
        endcase
        op2_in = 8'h00;
        case (bus.SEL_MUX_OP2)
            2'd0: op2_in = m_arg;
            2'd1: op2_in = ds_top;
            2'd2: op2_in = m_pc;
            default: op2_in = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp      <= 4'd0;
            fsp     <= 3'd0;
            m_instr <= 8'h00;
            m_pc    <= 8'h00;
        end else begin
            if (bus.CTRL_REG_INSTR) m_instr <= prog_op[m_pc];
            if (bus.CTRL_REG_ARG) m_arg <= prog_arg[m_pc];
            if (bus.CTRL_REG_JUMP) m_jump <= m_arg;
            if (bus.CTRL_REG_OP1) m_op1 <= op1_in;
            if (bus.CTRL_REG_OP2) m_op2 <= op2_in;
            if (bus.CTRL_REG_PC) m_pc <= bus.SEL_MUX_PC ? fs_top : ula_out;
            if (bus.CTRL_STACK_FUNCTION) fs[fsp] <= m_pc;
            if (bus.CTRL_REG_TOS_FUNCTION)
                fsp <= bus.SEL_SOMADOR_SUBTRATOR ? fsp - 3'd1 : fsp + 3'd1;
            if (bus.CTRL_REG_DATA_RETURN) m_ret <= ds_top;
            if (bus.CTRL_STACK) ds[sp] <= push_val;
            if (bus.CTRL_REG_TOS) sp <= bus.SEL_MUX_TOS ? sp - 4'd1 : sp + 4'd1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            prog_op[i]  = 8'hFF;
            prog_arg[i] = 8'h00;
        end
    endtask

    task automatic put(input int addr, input logic [7:0] op, input logic [7:0] arg);
        prog_op[addr]  = op;
        prog_arg[addr] = arg;
    endtask

    // Reset for two edges, release, and stop at the first FETCH.
    task automatic start_prog();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // From a FETCH sample point, run to the next FETCH (or HALT) and check the cycle count.
    task automatic run_instr(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.CTRL_REG_INSTR !== 1'b1 && bus.HALTED !== 1'b1 && n < 40);
        chk(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        clk     = 1'b0;
        reset   = 1'b0;
        comp_in = 1'b0;
        ovf_in  = 1'b0;
        total   = 0;
        bad     = 0;

        // LOAD_CONST 5, LOAD_CONST 3, BINARY_ADD, then an unknown opcode
        clear_prog();
        put(0, OpLoadConst, 8'd5);
        put(1, OpLoadConst, 8'd3);
        put(2, OpBinaryAdd, 8'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("init_sel_ula", 32'(bus.SEL_ULA), 32'hE);
        chk("init_pc_load", 32'(bus.CTRL_REG_PC), 1);
        chk("init_no_fetch", 32'(bus.CTRL_REG_INSTR), 0);
        reset = 1'b0;
        tick();
        chk("fetch_instr", 32'(bus.CTRL_REG_INSTR), 1);
        chk("fetch_pc0", 32'(m_pc), 0);
        run_instr("cpi_load5", 5);
        chk("pc_after_load5", 32'(m_pc), 1);
        run_instr("cpi_load3", 5);
        chk("pc_after_load3", 32'(m_pc), 2);
        chk("top_after_loads", 32'(ds_top), 3);
        tick();
        chk("add_decode_hold", 32'(bus.CTRL_REG_STACK), 0);
        tick();
        chk("add_ex1_op2", 32'(bus.CTRL_REG_OP2), 1);
        chk("add_ex1_pop", 32'(bus.CTRL_REG_STACK), 2);
        tick();
        chk("add_ex2_op1", 32'(bus.CTRL_REG_OP1), 1);
        tick();
        chk("add_ex3_push", 32'(bus.CTRL_REG_STACK), 1);
        chk("add_ex3_mux", 32'(bus.SEL_MUX_STACK), 3);
        chk("add_ex3_ula", 32'(bus.SEL_ULA), 0);
        tick();
        tick();
        tick();
        chk("add_next_fetch", 32'(bus.CTRL_REG_INSTR), 1);
        chk("pc_after_add", 32'(m_pc), 3);
        chk("add_result", 32'(ds_top), 8);
        chk("add_depth", 32'(sp), 1);
        run_instr("cpi_unknown", 2);
        chk("unknown_halted", 32'(bus.HALTED), 1);
        repeat (6) tick();
        chk("halt_sticky", 32'(bus.HALTED), 1);
        chk("halt_enables", 32'(enables), 0);

        // Reset held two cycles during ADD's EX2
        start_prog();
        run_instr("rst_load5", 5);
        run_instr("rst_load3", 5);
        tick();
        tick();
        tick();
        chk("rst_in_ex2", 32'(bus.CTRL_REG_OP1), 1);
        reset = 1'b1;
        tick();
        chk("rst_init_ula", 32'(bus.SEL_ULA), 32'hE);
        chk("rst_init_pc", 32'(bus.CTRL_REG_PC), 1);
        chk("rst_no_push1", 32'(bus.CTRL_REG_STACK), 0);
        tick();
        chk("rst_no_push2", 32'(bus.CTRL_REG_STACK), 0);
        reset = 1'b0;
        tick();
        chk("rst_refetch", 32'(bus.CTRL_REG_INSTR), 1);
        chk("rst_no_push3", 32'(bus.CTRL_REG_STACK), 0);
        chk("rst_pc0", 32'(m_pc), 0);

        // COMPARE_OP then POP_JUMP_IF_FALSE 0x20, compare flag low: jump taken
        clear_prog();
        put(0, OpLoadConst, 8'd2);
        put(1, OpLoadConst, 8'd7);
        put(2, OpCompareOp, 8'd0);
        put(3, OpPopJumpIfFalse, 8'h20);
        comp_in = 1'b0;
        start_prog();
        run_instr("cmp_load2", 5);
        run_instr("cmp_load7", 5);
        run_instr("cpi_compare", 7);
        chk("cmp_result", 32'(ds_top), 1);
        run_instr("cpi_popjump", 5);
        chk("popjump_taken_pc", 32'(m_pc), 32'h20);
        chk("popjump_popped", 32'(sp), 0);

        // Same sequence, compare flag high: falls through
        comp_in = 1'b1;
        start_prog();
        run_instr("cmp1_load2", 5);
        run_instr("cmp1_load7", 5);
        run_instr("cmp1_compare", 7);
        run_instr("cmp1_popjump", 5);
        chk("popjump_fallthru_pc", 32'(m_pc), 4);
        comp_in = 1'b0;

        // NOPs, CALL_FUNCTION 0x40 at PC 5, LOAD_CONST 9, RETURN_VALUE, JUMP_ABSOLUTE 0x10
        clear_prog();
        for (int i = 0; i < 5; i++) put(i, OpNop, 8'd0);
        put(5, OpCallFunction, 8'h40);
        put(6, OpJumpAbsolute, 8'h10);
        put(8'h40, OpLoadConst, 8'd9);
        put(8'h41, OpReturnValue, 8'd0);
        start_prog();
        for (int i = 0; i < 5; i++) run_instr("cpi_nop", 4);
        chk("pc_after_nops", 32'(m_pc), 5);
        run_instr("cpi_call", 5);
        chk("call_pc", 32'(m_pc), 32'h40);
        chk("call_fdepth", 32'(fsp), 1);
        chk("call_saved_pc", 32'(fs[0]), 5);
        run_instr("call_load9", 5);
        run_instr("cpi_return", 7);
        chk("return_pc", 32'(m_pc), 6);
        chk("return_value", 32'(ds_top), 9);
        chk("return_depth", 32'(sp), 1);
        chk("return_fdepth", 32'(fsp), 0);
        run_instr("cpi_jump", 5);
        chk("jump_pc", 32'(m_pc), 32'h10);
        run_instr("jump_then_halt", 2);
        chk("jump_halted", 32'(bus.HALTED), 1);

        // BINARY_ADD 0x7F + 0x01 with overflow flag: result written, then halt
        clear_prog();
        put(0, OpLoadConst, 8'h7F);
        put(1, OpLoadConst, 8'h01);
        put(2, OpBinaryAdd, 8'd0);
        put(3, OpNop, 8'd0);
        start_prog();
        run_instr("ovf_load7f", 5);
        run_instr("ovf_load1", 5);
        ovf_in = 1'b1;
        run_instr("ovf_add_to_halt", 5);
        chk("ovf_halted", 32'(bus.HALTED), 1);
        chk("ovf_result", 32'(ds_top), 32'h80);
        chk("ovf_depth", 32'(sp), 1);
        repeat (3) tick();
        chk("ovf_halt_sticky", 32'(bus.HALTED), 1);
        chk("ovf_pc_frozen", 32'(m_pc), 2);
        ovf_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
